// File: rtl/srs_rotation_engine.sv
// srs_rotation_engine: walks the SRS kick list for a rotate request and hands
// each candidate pose to an external collision checker over a req/ack handshake.
// The first free candidate wins; if every candidate is blocked, the rotation fails.
// Defining ROT_180_EN enables 180-degree rotation (rot_dir = 2'b10).
module srs_rotation_engine #(
    parameter int unsigned X_W            = 5,
    parameter int unsigned Y_W            = 6,
    parameter int unsigned TEST_POSITIONS = 5,
    parameter int unsigned IDX_W          = $clog2(TEST_POSITIONS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       piece,
    input  logic [1:0]       orient_in,
    input  logic [1:0]       rot_dir,
    input  logic [X_W-1:0]   x_in,
    input  logic [Y_W-1:0]   y_in,
    output logic             chk_req,
    output logic [X_W-1:0]   chk_x,
    output logic [Y_W-1:0]   chk_y,
    output logic [1:0]       chk_orient,
    input  logic             chk_ack,
    input  logic             chk_collide,
    output logic             busy,
    output logic             done,
    output logic             success,
    output logic [X_W-1:0]   x_out,
    output logic [Y_W-1:0]   y_out,
    output logic [1:0]       orient_out,
    output logic [IDX_W-1:0] kick_idx
);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    localparam logic [2:0]       PieceI     = 3'd0;
    localparam logic [2:0]       PieceO     = 3'd1;
    localparam logic [2:0]       PieceBad   = 3'd7;
    localparam logic [IDX_W-1:0] IdxFail    = IDX_W'(TEST_POSITIONS);
    localparam logic [IDX_W-1:0] IdxLast    = IDX_W'(TEST_POSITIONS - 1);
    localparam logic [IDX_W-1:0] Idx180Last = (TEST_POSITIONS >= 2) ? IDX_W'(1) : '0;

    // JLSTZ offsets {dx, dy} (3-bit two's complement, +y up); kick = off(from) - off(to).
    function automatic logic [5:0] jlstz_offset(input logic [1:0] o, input logic [2:0] i);
        logic [5:0] r;
        r = '0;
        if (o == 2'd1) begin
            case (i)
                3'd1:    r = {3'b001, 3'b000};
                3'd2:    r = {3'b001, 3'b111};
                3'd3:    r = {3'b000, 3'b010};
                3'd4:    r = {3'b001, 3'b010};
                default: r = '0;
            endcase
        end else if (o == 2'd3) begin
            case (i)
                3'd1:    r = {3'b111, 3'b000};
                3'd2:    r = {3'b111, 3'b111};
                3'd3:    r = {3'b000, 3'b010};
                3'd4:    r = {3'b111, 3'b010};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    // I kicks: list A serves the 0<->R and 2<->L pairs, list B the R<->2 and L<->0
    // pairs (from+to == 3); the reverse direction of each pair uses the negated list.
    function automatic logic [5:0] i_kick(input logic [1:0] from, input logic [1:0] to,
                                          input logic [2:0] i);
        logic [5:0] r;
        logic       use_b;
        logic       neg;
        use_b = ((3'(from) + 3'(to)) == 3'd3);
        neg   = ({from, to} == 4'b0100) || ({from, to} == 4'b1011) ||
                ({from, to} == 4'b1001) || ({from, to} == 4'b1100);
        case (i)
            3'd1:    r = use_b ? {3'b111, 3'b000} : {3'b110, 3'b000};
            3'd2:    r = use_b ? {3'b010, 3'b000} : {3'b001, 3'b000};
            3'd3:    r = use_b ? {3'b111, 3'b010} : {3'b110, 3'b111};
            3'd4:    r = use_b ? {3'b010, 3'b111} : {3'b001, 3'b010};
            default: r = '0;
        endcase
        if (neg) begin
            r = {3'(~r[5:3] + 3'd1), 3'(~r[2:0] + 3'd1)};
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [2:0]       piece_q;
    logic [1:0]       from_q, tgt_q;
    logic             r180_q;
    logic [IDX_W-1:0] last_q, idx_q;
    logic [X_W-1:0]   x_q;
    logic [Y_W-1:0]   y_q;

    logic             accept, advance, hit, miss;
    logic             start_r180, start_illegal;
    logic [1:0]       start_tgt;
    logic [IDX_W-1:0] start_last;

    logic [2:0]       base_piece;
    logic [1:0]       base_from, base_tgt;
    logic             base_r180;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [IDX_W-1:0] cand_idx;
    logic [2:0]       idx3, dx, dy;
    logic [5:0]       kick, jf, jt;
    logic [X_W-1:0]   cand_x;
    logic [Y_W-1:0]   cand_y;

    assign chk_req = (state_q == StReq);
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);

    // Decode the incoming request: target orientation, legality and last test index.
    always_comb begin
        start_r180 = (rot_dir == 2'b10);
        case (rot_dir)
            2'b01:   start_tgt = orient_in + 2'd1;
            2'b11:   start_tgt = orient_in - 2'd1;
            2'b10:   start_tgt = orient_in + 2'd2;
            default: start_tgt = orient_in;
        endcase
`ifdef ROT_180_EN
        start_illegal = (piece == PieceBad) || (rot_dir == 2'b00);
`else
        start_illegal = (piece == PieceBad) || (rot_dir == 2'b00) || start_r180;
`endif
        if (piece == PieceO) begin
            start_last = '0;
        end else if (start_r180) begin
            start_last = Idx180Last;
        end else begin
            start_last = IdxLast;
        end
    end

    // Next-state logic and the control strobes that drive the datapath.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        advance = 1'b0;
        hit     = 1'b0;
        miss    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    accept = 1'b1;
                    if (start_illegal) begin
                        miss    = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (chk_ack) begin
                    if (!chk_collide) begin
                        hit     = 1'b1;
                        state_d = StDone;
                    end else if (idx_q == last_q) begin
                        miss    = 1'b1;
                        state_d = StDone;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next candidate pose: from the live inputs on accept, else from the latched request.
    always_comb begin
        base_piece = accept ? piece     : piece_q;
        base_from  = accept ? orient_in : from_q;
        base_tgt   = accept ? start_tgt : tgt_q;
        base_r180  = accept ? start_r180 : r180_q;
        base_x     = accept ? x_in      : x_q;
        base_y     = accept ? y_in      : y_q;
        cand_idx   = accept ? '0 : idx_q + IDX_W'(1);
        idx3       = 3'(cand_idx);
        jf         = jlstz_offset(base_from, idx3);
        jt         = jlstz_offset(base_tgt, idx3);
        if (base_piece == PieceO) begin
            kick = '0;
        end else if (base_r180) begin
            kick = (idx3 == 3'd1) ? {3'b000, 3'b001} : '0;
        end else if (base_piece == PieceI) begin
            kick = i_kick(base_from, base_tgt, idx3);
        end else begin
            kick = {3'(jf[5:3] - jt[5:3]), 3'(jf[2:0] - jt[2:0])};
        end
        dx     = kick[5:3];
        dy     = kick[2:0];
        // Row index grows downward while the table's +y is up.
        cand_x = base_x + {{(X_W - 3){dx[2]}}, dx};
        cand_y = base_y - {{(Y_W - 3){dy[2]}}, dy};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, candidate registers and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            piece_q    <= '0;
            from_q     <= '0;
            tgt_q      <= '0;
            r180_q     <= 1'b0;
            last_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            idx_q      <= '0;
            chk_x      <= '0;
            chk_y      <= '0;
            chk_orient <= '0;
            success    <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            orient_out <= '0;
            kick_idx   <= '0;
        end else begin
            if (accept) begin
                piece_q <= piece;
                from_q  <= orient_in;
                tgt_q   <= start_tgt;
                r180_q  <= start_r180;
                last_q  <= start_last;
                x_q     <= x_in;
                y_q     <= y_in;
            end
            if (accept || advance) begin
                idx_q      <= cand_idx;
                chk_x      <= cand_x;
                chk_y      <= cand_y;
                chk_orient <= base_tgt;
            end
            if (hit) begin
                success    <= 1'b1;
                x_out      <= chk_x;
                y_out      <= chk_y;
                orient_out <= chk_orient;
                kick_idx   <= idx_q;
            end else if (miss) begin
                success    <= 1'b0;
                x_out      <= base_x;
                y_out      <= base_y;
                orient_out <= base_from;
                kick_idx   <= IdxFail;
            end
        end
    end

endmodule

// File: tb/tb_srs_rotation_engine.sv
// Bench for srs_rotation_engine: directed spec scenarios plus randomized rotations,
// compared against a table-driven SRS model and a scripted collision checker.
module tb_srs_rotation_engine;

    localparam int X_W = 5;
    localparam int Y_W = 6;
    localparam int TP  = 5;
    localparam int TP2 = 2;
    localparam int IW  = $clog2(TP) + 1;
    localparam int IW2 = $clog2(TP2) + 1;
    localparam int XM  = (1 << X_W) - 1;
    localparam int YM  = (1 << Y_W) - 1;
`ifdef ROT_180_EN
    localparam bit R180 = 1'b1;
`else
    localparam bit R180 = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1, start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
    logic [2:0]     piece = '0;
    logic [1:0]     orient_in = '0, rot_dir = '0;
    logic [X_W-1:0] x_in = '0;
    logic [Y_W-1:0] y_in = '0;

    logic           chk_req, chk_ack, chk_collide, busy, done, success;
    logic [X_W-1:0] chk_x, x_out;
    logic [Y_W-1:0] chk_y, y_out;
    logic [1:0]     chk_orient, orient_out;
    logic [IW-1:0]  kick_idx;

    logic           chk_req2, chk_ack2, chk_collide2, busy2, done2, success2;
    logic [X_W-1:0] chk_x2, x_out2;
    logic [Y_W-1:0] chk_y2, y_out2;
    logic [1:0]     chk_orient2, orient_out2;
    logic [IW2-1:0] kick_idx2;

    srs_rotation_engine #(.X_W(X_W), .Y_W(Y_W), .TEST_POSITIONS(TP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .piece(piece),
        .orient_in(orient_in), .rot_dir(rot_dir), .x_in(x_in), .y_in(y_in),
        .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_orient(chk_orient),
        .chk_ack(chk_ack), .chk_collide(chk_collide), .busy(busy), .done(done),
        .success(success), .x_out(x_out), .y_out(y_out), .orient_out(orient_out),
        .kick_idx(kick_idx)
    );

    // Second instance with a short kick list; its checker answers at once, always blocked.
    srs_rotation_engine #(.X_W(X_W), .Y_W(Y_W), .TEST_POSITIONS(TP2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .piece(piece),
        .orient_in(orient_in), .rot_dir(rot_dir), .x_in(x_in), .y_in(y_in),
        .chk_req(chk_req2), .chk_x(chk_x2), .chk_y(chk_y2), .chk_orient(chk_orient2),
        .chk_ack(chk_ack2), .chk_collide(chk_collide2), .busy(busy2), .done(done2),
        .success(success2), .x_out(x_out2), .y_out(y_out2), .orient_out(orient_out2),
        .kick_idx(kick_idx2)
    );
    assign chk_ack2     = chk_req2;
    assign chk_collide2 = 1'b1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scripted checker for dut: random wait per candidate, collision from mask cm.
    int         wmax = 0, acks = 0, total_wait = 0, wleft = -1;
    logic [4:0] cm = '0;
    int         log_x[$], log_y[$], log_o[$];
    int         l2_x[$], l2_y[$], l2_o[$];

    initial begin
        chk_ack     = 1'b0;
        chk_collide = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_req) begin
                if (wleft < 0) begin
                    wleft = int'($urandom_range(32'(wmax), 0));
                    total_wait += wleft;
                end
                if (wleft == 0) begin
                    chk_ack     = 1'b1;
                    chk_collide = (acks < 5) ? cm[acks] : 1'b1;
                    log_x.push_back(int'(chk_x));
                    log_y.push_back(int'(chk_y));
                    log_o.push_back(int'(chk_orient));
                    acks++;
                    wleft = -1;
                end else begin
                    wleft--;
                end
            end else begin
                wleft = -1;
            end
            @(posedge clk);
            #1;
            chk_ack     = 1'b0;
            chk_collide = 1'b0;
        end
    end

    // Candidate log for dut2.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_req2) begin
                l2_x.push_back(int'(chk_x2));
                l2_y.push_back(int'(chk_y2));
                l2_o.push_back(int'(chk_orient2));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Standard SRS kick tables, (dx, dy) with +y up, indexed by from*4+to.
    task automatic table_kick(input bit is_i, input int from, input int to, input int i,
                              output int dx, output int dy);
        int kx[5];
        int ky[5];
        kx = '{0, 0, 0, 0, 0};
        ky = '{0, 0, 0, 0, 0};
        if (is_i) begin
            case (from * 4 + to)
                1, 14: begin kx = '{0, -2, 1, -2, 1}; ky = '{0, 0, 0, -1, 2}; end
                4, 11: begin kx = '{0, 2, -1, 2, -1}; ky = '{0, 0, 0, 1, -2}; end
                6, 3:  begin kx = '{0, -1, 2, -1, 2}; ky = '{0, 0, 0, 2, -1}; end
                9, 12: begin kx = '{0, 1, -2, 1, -2}; ky = '{0, 0, 0, -2, 1}; end
                default: ;
            endcase
        end else begin
            case (from * 4 + to)
                1, 9:  begin kx = '{0, -1, -1, 0, -1}; ky = '{0, 0, 1, -2, -2}; end
                4, 6:  begin kx = '{0, 1, 1, 0, 1};    ky = '{0, 0, -1, 2, 2}; end
                11, 3: begin kx = '{0, 1, 1, 0, 1};    ky = '{0, 0, 1, -2, -2}; end
                14, 12: begin kx = '{0, -1, -1, 0, -1}; ky = '{0, 0, -1, 2, 2}; end
                default: ;
            endcase
        end
        dx = kx[i];
        dy = ky[i];
    endtask

    int exp_n, exp_ok, exp_x, exp_y, exp_o, exp_idx, exp_co;
    int exp_cx[5], exp_cy[5];

    task automatic model(input int pc, input int o, input int d, input int x, input int y,
                         input int tp, input logic [4:0] m);
        int  t, n, dx, dy;
        bit  legal;
        legal  = (pc != 7) && (d != 0) && ((d != 2) || R180);
        t      = (d == 1) ? (o + 1) % 4 : (d == 3) ? (o + 3) % 4 : (o + 2) % 4;
        exp_n  = 0;
        exp_ok = 0;
        exp_x  = x;
        exp_y  = y;
        exp_o  = o;
        exp_idx = tp;
        exp_co = t;
        if (!legal) return;
        if (pc == 1) n = 1;
        else if (d == 2) n = (tp < 2) ? tp : 2;
        else n = tp;
        for (int i = 0; i < n; i++) begin
            if (pc == 1) begin
                dx = 0;
                dy = 0;
            end else if (d == 2) begin
                dx = 0;
                dy = (i == 1) ? 1 : 0;
            end else begin
                table_kick(pc == 0, o, t, i, dx, dy);
            end
            exp_cx[i] = (x + dx) & XM;
            exp_cy[i] = (y - dy) & YM;
            exp_n++;
            if (!m[i]) begin
                exp_ok  = 1;
                exp_x   = exp_cx[i];
                exp_y   = exp_cy[i];
                exp_o   = t;
                exp_idx = i;
                return;
            end
        end
    endtask

    task automatic run(input string tag, input int pc, input int o, input int d, input int x,
                       input int y, input logic [4:0] m, input int w);
        int cyc;
        model(pc, o, d, x, y, TP, m);
        cm = m;
        wmax = w;
        acks = 0;
        total_wait = 0;
        log_x.delete();
        log_y.delete();
        log_o.delete();
        piece     = 3'(pc);
        orient_in = 2'(o);
        rot_dir   = 2'(d);
        x_in      = X_W'(x);
        y_in      = Y_W'(y);
        start     = 1'b1;
        @(posedge clk);
        #1;
        // Scrambled inputs and a stray start while busy must be ignored.
        piece     = 3'($urandom);
        orient_in = 2'($urandom);
        rot_dir   = 2'($urandom);
        x_in      = X_W'($urandom);
        y_in      = Y_W'($urandom);
        cyc = 1;
        check({tag, " busy"}, busy, 1);
        while (done !== 1'b1 && cyc < 60) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        check({tag, " done"}, done, 1);
        check({tag, " latency"}, cyc, 1 + exp_n + total_wait);
        check({tag, " success"}, success, exp_ok);
        check({tag, " x_out"}, x_out, exp_x);
        check({tag, " y_out"}, y_out, exp_y);
        check({tag, " orient_out"}, orient_out, exp_o);
        check({tag, " kick_idx"}, kick_idx, exp_idx);
        check({tag, " n_cand"}, acks, exp_n);
        for (int i = 0; i < exp_n && i < log_x.size(); i++) begin
            check({tag, " cand_x"}, log_x[i], exp_cx[i]);
            check({tag, " cand_y"}, log_y[i], exp_cy[i]);
            check({tag, " cand_o"}, log_o[i], exp_co);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " done_pulse"}, done, 0);
        check({tag, " idle"}, busy, 0);
    endtask

    task automatic cancel_run(input string tag, input bit use_rst);
        int dn;
        cm = 5'b11111;
        wmax = 0;
        acks = 0;
        piece     = 3'd2;
        orient_in = 2'd0;
        rot_dir   = 2'b01;
        x_in      = X_W'(4);
        y_in      = Y_W'(10);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " mid req"}, chk_req, 1);
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        abort = 1'b0;
        check({tag, " chk_req"}, chk_req, 0);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        if (use_rst) begin
            check({tag, " success"}, success, 0);
            check({tag, " x_out"}, x_out, 0);
            check({tag, " y_out"}, y_out, 0);
            check({tag, " orient_out"}, orient_out, 0);
            check({tag, " kick_idx"}, kick_idx, 0);
            check({tag, " chk_x"}, chk_x, 0);
            check({tag, " chk_y"}, chk_y, 0);
            check({tag, " chk_orient"}, chk_orient, 0);
        end else begin
            check({tag, " success"}, success, exp_ok);
            check({tag, " x_out"}, x_out, exp_x);
            check({tag, " y_out"}, y_out, exp_y);
            check({tag, " orient_out"}, orient_out, exp_o);
            check({tag, " kick_idx"}, kick_idx, exp_idx);
        end
        dn = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            dn += int'(done);
        end
        check({tag, " no done"}, dn, 0);
    endtask

    initial begin
        int plist[6];
        int cyc;
        plist = '{0, 1, 2, 3, 4, 7};
        repeat (3) @(posedge clk);
        #1;
        check("reset chk_req", chk_req, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset success", success, 0);
        check("reset kick_idx", kick_idx, 0);
        check("reset x_out", x_out, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run("t_cw", 2, 0, 1, 4, 10, 5'b00001, 0);
        check("t_cw spec x", x_out, 3);
        check("t_cw spec idx", kick_idx, 1);
        run("i_fail", 0, 0, 1, 4, 10, 5'b11111, 0);
        check("i_fail spec idx", kick_idx, 5);
        run("o_ccw", 1, 0, 3, 4, 0, 5'b00000, 0);
        run("t_180", 2, 0, 2, 4, 10, 5'b00001, 0);
        run("bad_piece", 7, 1, 1, 3, 3, 5'b00000, 0);
        run("bad_dir", 3, 2, 0, 6, 20, 5'b00000, 0);
        run("j_wait", 3, 3, 3, 0, 0, 5'b00111, 2);

        // Short kick list on dut2.
        model(3, 1, 1, 0, 5, TP2, 5'b11111);
        l2_x.delete();
        l2_y.delete();
        l2_o.delete();
        piece     = 3'd3;
        orient_in = 2'd1;
        rot_dir   = 2'b01;
        x_in      = X_W'(0);
        y_in      = Y_W'(5);
        start2    = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        cyc = 1;
        while (done2 !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("tp2 done", done2, 1);
        check("tp2 n_cand", l2_x.size(), exp_n);
        for (int i = 0; i < exp_n && i < l2_x.size(); i++) begin
            check("tp2 cand_x", l2_x[i], exp_cx[i]);
            check("tp2 cand_y", l2_y[i], exp_cy[i]);
            check("tp2 cand_o", l2_o[i], exp_co);
        end
        check("tp2 success", success2, 0);
        check("tp2 kick_idx", kick_idx2, 2);
        check("tp2 x_out", x_out2, 0);
        check("tp2 y_out", y_out2, 5);
        check("tp2 orient_out", orient_out2, 1);
        @(posedge clk);
        #1;

        run("pre_abort", 2, 0, 1, 4, 10, 5'b00001, 0);
        cancel_run("abort", 1'b0);
        cancel_run("rst", 1'b1);

        for (int k = 0; k < 40; k++) begin
            run("rand", plist[$urandom_range(5, 0)], int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(XM, 0)),
                int'($urandom_range(YM, 0)), 5'($urandom), int'($urandom_range(2, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
